jam_cost_host: RTL and testbench

- Counterpart to the JAM job-assignment engine on the W/J/Cost interface.
- Holds the 8x8 worker/job cost table, which is loaded through a valid/ready stream.
- Serves Cost for the W/J indices the engine drives, and holds the engine in reset until the table is complete.
- Monitors Valid, then checks the engine's MinCost/MatchCount against expected values and reports pass/fail/timeout with a cycle count.

---
 rtl/jam_cost_host.sv | 99 +++++++++
 tb/tb_jam_cost_host.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_host.sv
// jam_cost_host: cost-table host and result checker for the JAM job-assignment engine
// Ports:
//   CLK, RST_N                  clock (rising edge), asynchronous active-low reset
//   load_valid/load_ready/load_data   row-major 64-beat cost table load stream
//   exp_min, exp_count          expected engine results, latched with the 64th beat
//   restart                     DONE -> LOAD pulse
//   jam_rst                     active-high reset to the engine, low only in RUN
//   W, J, Cost                  engine cost lookup (combinational, zero outside RUN)
//   MinCost, MatchCount, Valid  engine results
//   done, pass, fail, timeout   check outcome; cycles = RUN cycles before Valid/timeout
module jam_cost_host #(
  parameter int TIMEOUT  = 1000000,
  parameter int HOLD_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [6:0]  load_data,
  input  logic [9:0]  exp_min,
  input  logic [3:0]  exp_count,
  input  logic        restart,
  output logic        jam_rst,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic [9:0]  MinCost,
  input  logic [3:0]  MatchCount,
  input  logic        Valid,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [19:0] cycles
);
  typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [6:0]  cost_mem [64];
  logic [5:0]  idx;
  logic [7:0]  hold_cnt;
  logic [9:0]  exp_min_q;
  logic [3:0]  exp_count_q;
  logic [19:0] cyc_inc;
  logic        accept, match, expired;
  // load_ready is gated by RST_N so it drops the moment reset asserts
  assign load_ready = (state == LOAD) && RST_N;
  assign accept     = load_valid && load_ready;
  assign jam_rst    = state != RUN;
  assign Cost       = (state == RUN) ? cost_mem[{W, J}] : 7'd0;
  assign match      = (MinCost == exp_min_q) && (MatchCount == exp_count_q);
  assign cyc_inc    = &cycles ? cycles : cycles + 20'd1;
  // Valid has priority: a timeout only counts when Valid is low on that edge
  assign expired    = !Valid && (cyc_inc >= 20'(TIMEOUT));
  always_comb begin
    state_n = state;
    state_n = (state == LOAD) ? ((accept && idx == 6'd63) ? HOLD : LOAD) :
              (state == HOLD) ? ((hold_cnt == 8'(HOLD_CYC - 1)) ? RUN : HOLD) :
              (state == RUN)  ? ((Valid || expired) ? DONE : RUN) :
                                (restart ? LOAD : DONE);
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= LOAD;
      idx         <= 6'd0;
      hold_cnt    <= 8'd0;
      cycles      <= 20'd0;
      exp_min_q   <= 10'd0;
      exp_count_q <= 4'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= (state == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      if (accept) idx <= idx + 6'd1;
      if (accept && idx == 6'd63) begin
        exp_min_q   <= exp_min;
        exp_count_q <= exp_count;
      end
      if (state == HOLD) cycles <= 20'd0;
      else if (state == RUN && !Valid) cycles <= cyc_inc;
      if (state == RUN && state_n == DONE) begin
        done    <= 1'b1;
        pass    <= Valid && match;
        fail    <= Valid && !match;
        timeout <= !Valid;
      end else if (state == DONE && restart) begin
        done    <= 1'b0;
        pass    <= 1'b0;
        fail    <= 1'b0;
        timeout <= 1'b0;
      end
    end
  end
  // Table is deliberately not reset; it is always fully rewritten before a run
  always_ff @(posedge CLK)
    if (accept) cost_mem[idx] <= load_data;
endmodule

// File: tb/tb_jam_cost_host.sv
// tb_jam_cost_host: directed, table-driven checks of jam_cost_host
module tb_jam_cost_host;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [6:0]  load_data = 7'd0;
  logic [9:0]  exp_min = 10'd0;
  logic [3:0]  exp_count = 4'd0;
  logic        restart = 1'b0;
  logic        jam_rst;
  logic [2:0]  w = 3'd0;
  logic [2:0]  j = 3'd0;
  logic [6:0]  cost;
  logic [9:0]  min_cost = 10'd0;
  logic [3:0]  match_count = 4'd0;
  logic        valid = 1'b0;
  logic        done, pass, fail, timeout;
  logic [19:0] cycles;
  int total = 0;
  int bad = 0;

  jam_cost_host #(.TIMEOUT(100), .HOLD_CYC(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .exp_min(exp_min), .exp_count(exp_count), .restart(restart),
    .jam_rst(jam_rst), .W(w), .J(j), .Cost(cost), .MinCost(min_cost),
    .MatchCount(match_count), .Valid(valid), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .cycles(cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct {int w; int j; int c;} cost_vec_t;
  typedef struct {int n; int mn; int cnt; bit p; bit f;} run_vec_t;
  cost_vec_t cvec [4];
  run_vec_t  rvec [4];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // beats k0..k1-1 with data k^mask; expected values are garbage except on beat 63
  task automatic load(input int k0, input int k1, input int gap, input logic [6:0] mask,
                      input logic [9:0] em, input logic [3:0] ec);
    for (int k = k0; k < k1; k++) begin
      if (gap != 0) begin
        load_valid = 1'b0;
        load_data  = 7'($urandom);
        exp_min    = 10'd999;
        exp_count  = 4'd15;
        step();
      end
      load_valid = 1'b1;
      load_data  = 7'(k) ^ mask;
      exp_min    = (k == 63) ? em : 10'd777;
      exp_count  = (k == 63) ? ec : 4'd9;
      step();
    end
    load_valid = 1'b0;
    exp_min    = 10'd555;
    exp_count  = 4'd7;
  endtask

  // called right after the 64th beat edge; ends on the first RUN cycle
  task automatic hold_check();
    chk("hold_ready", load_ready, 0);
    chk("hold_rst0", jam_rst, 1);
    w = 3'd5; j = 3'd3; #1;
    chk("cost_pre_run", cost, 0);
    step();
    chk("hold_rst1", jam_rst, 1);
    step();
    chk("run_rst", jam_rst, 0);
    chk("run_cycles0", cycles, 0);
  endtask

  task automatic engine(input int n, input int mn, input int cnt, input bit ep, input bit ef);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_ignored", done, 0);
    repeat (n - 1) step();
    valid = 1'b1; min_cost = 10'(mn); match_count = 4'(cnt);
    step();
    valid = 1'b0;
    chk("done", done, 1);
    chk("pass", pass, ep);
    chk("fail", fail, ef);
    chk("timeout_v", timeout, 0);
    chk("cycles", cycles, n);
    chk("done_rst", jam_rst, 1);
    valid = 1'b1; min_cost = 10'd0; match_count = 4'd0;
    step();
    valid = 1'b0;
    chk("held_pass", pass, ep);
    chk("held_cycles", cycles, n);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_ready", load_ready, 1);
    chk("rs_done", done, 0);
    chk("rs_flags", {pass, fail, timeout}, 0);
  endtask

  initial begin
    cvec[0] = '{5, 3, 43};
    cvec[1] = '{7, 7, 63};
    cvec[2] = '{0, 0, 0};
    cvec[3] = '{2, 6, 22};
    rvec[0] = '{50, 224, 1, 1, 0};
    rvec[1] = '{50, 223, 1, 0, 1};
    rvec[2] = '{20, 224, 2, 0, 1};
    rvec[3] = '{99, 224, 1, 1, 0};
    #2;
    chk("rst_ready", load_ready, 0);
    chk("rst_jam", jam_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_cost", cost, 0);
    step();
    RST_N = 1'b1;
    #1;
    chk("ready", load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) do_restart();
      load(0, 64, 0, 7'd0, 10'd224, 4'd1);
      hold_check();
      if (i == 0)
        for (int c = 0; c < 4; c++) begin
          w = 3'(cvec[c].w); j = 3'(cvec[c].j); #1;
          chk($sformatf("cost_%0d_%0d", cvec[c].w, cvec[c].j), cost, cvec[c].c);
        end
      engine(rvec[i].n, rvec[i].mn, rvec[i].cnt, rvec[i].p, rvec[i].f);
    end
    do_restart();
    load(0, 64, 1, 7'h7f, 10'd300, 4'd5);
    hold_check();
    w = 3'd0; j = 3'd0; #1; chk("gap_cost00", cost, 127);
    w = 3'd7; j = 3'd7; #1; chk("gap_cost77", cost, 64);
    w = 3'd3; j = 3'd4; #1; chk("gap_cost34", cost, 99);
    engine(10, 300, 5, 1, 0);
    do_restart();
    load(0, 64, 0, 7'd0, 10'd224, 4'd1);
    hold_check();
    begin
      int n;
      n = 0;
      while (!done && n < 150) begin
        step();
        n++;
      end
      chk("to_steps", n, 100);
    end
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_pf", {pass, fail}, 0);
    chk("to_cycles", cycles, 100);
    do_restart();
    load(0, 30, 0, 7'd0, 10'd224, 4'd1);
    load_valid = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("async_ready", load_ready, 0);
    chk("async_jam", jam_rst, 1);
    step();
    RST_N = 1'b1;
    load_valid = 1'b0;
    load(0, 63, 0, 7'h2a, 10'd42, 4'd3);
    chk("fresh63_ready", load_ready, 1);
    chk("fresh63_jam", jam_rst, 1);
    load(63, 64, 0, 7'h2a, 10'd42, 4'd3);
    hold_check();
    w = 3'd0; j = 3'd0; #1; chk("fresh_cost00", cost, 42);
    engine(5, 42, 3, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
